// File: rtl/regfile_write_arbiter.sv
// Round-robin merge of two write requesters onto the register file write port, with a walk that zeroes every register.
// Write outputs are registered: a grant in cycle T appears at the port in T+1.
`timescale 1ns/1ps

module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   input  logic [ADDR_WIDTH-1:0] a_reg,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  b_valid,
   input  logic [ADDR_WIDTH-1:0] b_reg,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   input  logic                  init_req,
   output logic                  init_done,
   output logic                  busy,
   output logic                  write,
   output logic [ADDR_WIDTH-1:0] write_reg,
   output logic [DATA_WIDTH-1:0] write_data
);

   typedef enum logic {RUN, INIT} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_REG = '1;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
   logic                  ptr, ptr_nxt;
   logic                  write_nxt, init_done_nxt;
   logic [ADDR_WIDTH-1:0] write_reg_nxt;
   logic [DATA_WIDTH-1:0] write_data_nxt;

   assign busy = (state == INIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         cnt        <= '0;
         ptr        <= 1'b0;
         write      <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         init_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ptr        <= ptr_nxt;
         write      <= write_nxt;
         write_reg  <= write_reg_nxt;
         write_data <= write_data_nxt;
         init_done  <= init_done_nxt;
      end
   end

   // cnt always equals the register being zeroed in the current INIT cycle
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      ptr_nxt        = ptr;
      a_ready        = 1'b0;
      b_ready        = 1'b0;
      write_nxt      = 1'b0;
      write_reg_nxt  = write_reg;
      write_data_nxt = write_data;
      init_done_nxt  = 1'b0;
      case (state)
         RUN: begin
            if (init_req) begin
               state_nxt      = INIT;
               cnt_nxt        = '0;
               write_nxt      = 1'b1;
               write_reg_nxt  = '0;
               write_data_nxt = '0;
            end else begin
               a_ready = a_valid && (!b_valid || !ptr);
               b_ready = b_valid && (!a_valid || ptr);
               if (a_ready) begin
                  write_nxt      = (a_reg != '0);
                  write_reg_nxt  = a_reg;
                  write_data_nxt = a_data;
                  ptr_nxt        = 1'b1;
               end else if (b_ready) begin
                  write_nxt      = (b_reg != '0);
                  write_reg_nxt  = b_reg;
                  write_data_nxt = b_data;
                  ptr_nxt        = 1'b0;
               end
            end
         end
         INIT: begin
            if (cnt == LAST_REG) begin
               state_nxt     = RUN;
               init_done_nxt = 1'b1;
            end else begin
               cnt_nxt        = cnt + 1'b1;
               write_nxt      = 1'b1;
               write_reg_nxt  = cnt + 1'b1;
               write_data_nxt = '0;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a cycle model predicts readies/busy/init_done
// and queues expected port writes, which a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_regfile_write_arbiter;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } req_t;

   typedef struct {
      int          due;
      logic [4:0]  r;
      logic [31:0] d;
   } exp_t;

   logic        clk, rst;
   logic        a_valid, b_valid, a_ready, b_ready;
   logic [4:0]  a_reg, b_reg, write_reg;
   logic [31:0] a_data, b_data, write_data;
   logic        init_req, init_done, busy, write;

   req_t qa[$];
   req_t qb[$];
   exp_t exp_q[$];

   int   nchk = 0;
   int   nerr = 0;
   int   cyc  = 0;
   int   m_left = 0;
   bit   m_done = 0;
   bit   m_ptr  = 0;

   regfile_write_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
      .init_req(init_req), .init_done(init_done), .busy(busy),
      .write(write), .write_reg(write_reg), .write_data(write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Every out-of-reset cycle: either the due write appears, or the port is idle
   always @(negedge clk) begin
      if (rst) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("write", 32'(write), 1);
            chk("write_reg", 32'(write_reg), 32'(exp_q[0].r));
            chk("write_data", write_data, exp_q[0].d);
            void'(exp_q.pop_front());
         end else begin
            chk("write_idle", 32'(write), 0);
         end
      end
   end

   task automatic tick(input logic ir);
      logic ea, eb;
      req_t ra, rb;
      @(negedge clk);
      a_valid = (qa.size() > 0);
      b_valid = (qb.size() > 0);
      if (a_valid) begin ra = qa[0]; a_reg = ra.r; a_data = ra.d; end
      else begin a_reg = 5'($urandom); a_data = $urandom; end
      if (b_valid) begin rb = qb[0]; b_reg = rb.r; b_data = rb.d; end
      else begin b_reg = 5'($urandom); b_data = $urandom; end
      init_req = ir;
      #1;
      if (m_left > 0) begin
         chk("busy_init", 32'(busy), 1);
         chk("init_done_in_init", 32'(init_done), 0);
         chk("a_ready_init", 32'(a_ready), 0);
         chk("b_ready_init", 32'(b_ready), 0);
         m_left--;
         m_done = (m_left == 0);
      end else begin
         chk("busy_run", 32'(busy), 0);
         chk("init_done", 32'(init_done), 32'(m_done));
         m_done = 0;
         ea = !ir && a_valid && (!b_valid || !m_ptr);
         eb = !ir && b_valid && (!a_valid || m_ptr);
         chk("a_ready", 32'(a_ready), 32'(ea));
         chk("b_ready", 32'(b_ready), 32'(eb));
         if (ir) begin
            for (int i = 0; i < 32; i++) exp_q.push_back('{cyc + 1 + i, 5'(i), 32'h0});
            m_left = 32;
         end else if (ea) begin
            if (ra.r != 5'd0) exp_q.push_back('{cyc + 1, ra.r, ra.d});
            void'(qa.pop_front());
            m_ptr = 1;
         end else if (eb) begin
            if (rb.r != 5'd0) exp_q.push_back('{cyc + 1, rb.r, rb.d});
            void'(qb.pop_front());
            m_ptr = 0;
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      a_valid = 0; b_valid = 0; a_reg = 0; b_reg = 0; a_data = 0; b_data = 0;
      init_req = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_write", 32'(write), 0);
      chk("rst_write_reg", 32'(write_reg), 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b1;

      // single A write, then a register-0 write from B
      qa.push_back('{5'd5, 32'hDEADBEEF});
      repeat (3) tick(1'b0);
      qb.push_back('{5'd0, 32'h1234});
      repeat (3) tick(1'b0);

      // contention: grants alternate starting with A
      for (int i = 0; i < 4; i++) begin
         qa.push_back('{5'(1 + i), 32'hA000_0000 + 32'(i)});
         qb.push_back('{5'(9 + i), 32'hB000_0000 + 32'(i)});
      end
      repeat (10) tick(1'b0);

      // zeroing with A waiting; A is granted in the init_done cycle
      qa.push_back('{5'd7, 32'hCAFE_F00D});
      tick(1'b1);
      repeat (36) tick(1'b0);

      // reset while the walk is at register 17
      tick(1'b1);
      repeat (18) tick(1'b0);
      #2 rst = 1'b0;
      exp_q.delete();
      m_left = 0; m_done = 0; m_ptr = 0;
      #1;
      chk("arst_write", 32'(write), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_init_done", 32'(init_done), 0);
      chk("arst_write_reg", 32'(write_reg), 0);
      @(negedge clk);
      rst = 1'b1;
      qb.push_back('{5'd20, 32'h5555_AAAA});
      qa.push_back('{5'd21, 32'h0F0F_0F0F});
      repeat (6) tick(1'b0);

      // init_req held: two walks back to back
      repeat (40) tick(1'b1);
      repeat (30) tick(1'b0);
      qa.push_back('{5'd31, 32'h8000_0001});
      repeat (4) tick(1'b0);

      chk("queue_drain", 32'(exp_q.size()), 0);
      chk("model_idle", 32'(m_left), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the 32x32 register file's single write port. It merges two independent write requesters onto one write channel with valid/ready handshakes and round-robin fairness; requester A is writeback and requester B is the load/debug path. It also provides a zeroing sequence that walks all registers on request. Its outputs drive the register file's `write`, `write_reg` and `write_data` inputs directly.

## Interface
- `DATA_WIDTH`, 32: width of write data.
- `ADDR_WIDTH`, 5: register address width; NUM_REGS = 2**ADDR_WIDTH.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  requester A has a write pending.
- `a_reg`  in  ADDR_WIDTH  requester A target register.
- `a_data`  in  DATA_WIDTH  requester A write data.
- `a_ready`  out  1  requester A's write is accepted this cycle.
- `b_valid`, `b_reg`, `b_data`, `b_ready`: the same four signals for requester B.
- `init_req`  in  1  request to zero all registers.
- `init_done`  out  1  one-cycle pulse when the zeroing sequence completes.
- `busy`  out  1  high while the zeroing sequence runs.
- `write`  out  1  register file write enable.
- `write_reg`  out  ADDR_WIDTH  register file write address.
- `write_data`  out  DATA_WIDTH  register file write data.

## Operation
- There are two states: RUN and INIT. Reset enters RUN.
- **Reset values:** `write`=0, `write_reg`=0, `write_data`=0, `init_done`=0, `busy`=0, zeroing counter=0, priority pointer=A.
- **RUN, handshake:**
  - A transfer occurs when `x_valid` && `x_ready`.
  - Ready is combinational from the current state, the valids, `init_req` and the pointer.
  - At most one ready is high per cycle.
  - Ready never depends on the requester's reg or data values.
- **RUN, arbitration:**
  - If only one valid is high, that requester gets ready.
  - If both are high, the requester named by the pointer gets ready.
  - After any transfer, the pointer moves to the other requester. With no transfer, the pointer holds.
- **RUN, init request:** if `init_req`=1, both readys are 0 that cycle and the next state is INIT with counter=0.
- **Register 0:** a transfer with target register 0 completes the handshake normally, but `write` stays 0 for it.
- **Idle / write pulse:** with no transfer, the next-cycle `write`=0. `write_reg` and `write_data` hold their last values.
- **INIT:**
  - `busy`=1 and both readys are 0.
  - Each cycle drives `write`=1, `write_reg`=counter, `write_data`=0, then the counter increments.
  - After the counter reaches NUM_REGS-1, the next state is RUN and `init_done` pulses for one cycle.
  - Register 0 is included in the walk; the register file ignores it.
  - `init_req` is ignored while in INIT.
- **Requester rules:** a requester holds its reg and data stable while valid is high and not yet accepted. The block tolerates violations; the values sampled on the transfer cycle are the ones used.
- **Counter width:** the counter is ADDR_WIDTH bits and is bounded by the state change to RUN, so it never wraps.

## Timing
- **Write latency:** a transfer in cycle T makes `write`/`write_reg`/`write_data` visible in cycle T+1, since they are registered. Back-to-back transfers give a continuous `write`=1 stream.
- **Zeroing sequence:**
  - `init_req` sampled high in cycle T gives `busy`=1 in cycles T+1..T+NUM_REGS.
  - Zero writes to registers 0..NUM_REGS-1 appear in cycles T+1..T+NUM_REGS.
  - `init_done`=1 and `busy`=0 in cycle T+NUM_REGS+1; grants may resume in that same cycle.
  - Total: 32 cycles of INIT for the default parameters.
- **`init_req` together with valids in RUN:** no transfer that cycle; `init_req` wins.
- **`init_req` held high:** the zeroing sequence re-triggers in the first RUN cycle after `init_done`.
- **Reset mid-INIT:**
  - All outputs return to reset values immediately (asynchronous).
  - No `init_done` pulse is produced.
  - After `rst` deasserts, the block is in RUN; the partially zeroed register file is left as-is.
- **Reset mid-handshake:** a transfer in the cycle of reset assertion is lost, and its `write` never appears.

## Test plan
- **Single requester:** after reset, A drives valid with reg=5, data=0xDEADBEEF for 1 cycle → `a_ready`=1 that cycle; next cycle `write`=1, `write_reg`=5, `write_data`=0xDEADBEEF; the cycle after, `write`=0.
- **Contention:** A and B both valid for 4 cycles (A: reg 1..4, B: reg 9..12), each holding a request until accepted → grants alternate A,B,A,B; the write port shows 1, 9, 2, 10 on consecutive cycles, each one cycle after its grant.
- **Register 0:** B valid with reg=0, data=0x1234 → `b_ready`=1 and the handshake completes, but `write` stays 0 the next cycle.
- **Zeroing sequence:** pulse `init_req` while A is valid → `a_ready`=0; `busy` high for 32 cycles; `write_reg` steps 0..31 with data 0; `init_done` pulses in cycle T+33; `a_ready`=1 that same cycle, with A's write visible the cycle after.
- **Reset mid-INIT:** assert `rst`=0 asynchronously at counter=17 → `write`, `busy`, `init_done` go to 0 immediately; after release the block is in RUN, grants work, and no `init_done` appears.
- **Held `init_req`:** keep `init_req`=1 for 40 cycles → two back-to-back zeroing sequences; the second starts the cycle after the first `init_done`; `init_req` is ignored during INIT.
